// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle datapath and its control FSM.
//   master : datapath side, drives opcode/mem_ready and receives controls.
//   slave  : FSM side, samples opcode/mem_ready and drives all controls.
// Signals:
//   opcode[5:0]   instruction bits [31:26] from the instruction register
//   mem_ready     memory finished the current access this cycle
//   IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
//   PCWrite, PCWriteCond, BranchNe, illegal, instr_done   1-bit controls
//   ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0]                  2-bit controls
//   state[3:0]    current state code
interface multicycle_control_fsm_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       RegWrite;
  logic       ALUSrcA;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       illegal;
  logic       instr_done;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSrc;
  logic [3:0] state;

  modport master (
    output opcode, mem_ready,
    input  IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCWrite, PCWriteCond, BranchNe, illegal, instr_done,
           ALUSrcB, ALUOp, PCSrc, state
  );

  modport slave (
    input  opcode, mem_ready,
    output IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, PCWrite, PCWriteCond, BranchNe, illegal, instr_done,
           ALUSrcB, ALUOp, PCSrc, state
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Moore control FSM for a MIPS-style multicycle datapath
// (lw, sw, R-type, beq, bne, j and optionally addi).
// Parameters:
//   MEM_HANDSHAKE  1: FETCH/MEMRD/MEMWR wait on mem_ready; 0: mem_ready ignored
//   ENABLE_IMM     1: addi supported; 0: addi decodes as illegal
// Ports:
//   clk    single rising-edge clock
//   reset  synchronous, active-high; forces FETCH and blanks all outputs
//   bus    slave side of multicycle_control_fsm_if (opcode/mem_ready in,
//          every control and the state code out)
module multicycle_control_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int ENABLE_IMM    = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  multicycle_control_fsm_if.slave   bus
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IMMEX  = 4'd10,
    S_IMMWB  = 4'd11
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       illegal;
    logic       instr_done;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_src;
  } ctrl_t;

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_t      ctrl;
  logic       ready;

  // Without the handshake every memory access completes in one cycle.
  assign ready = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ctrl    = '0;

    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'b01;
        // Only commit IR and PC+4 on the cycle the fetch actually completes.
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
        if (ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'b11;
        op_d           = bus.opcode;
        case (bus.opcode)
          OP_RTYPE:       state_d = S_EXEC;
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          OP_ADDI: begin
            if (ENABLE_IMM != 0) begin
              state_d = S_IMMEX;
            end else begin
              ctrl.illegal = 1'b1;
              state_d      = S_FETCH;
            end
          end
          default: begin
            ctrl.illegal = 1'b1;
            state_d      = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        ctrl.iord     = 1'b1;
        ctrl.mem_read = 1'b1;
        if (ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ctrl.mem_to_reg = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWR: begin
        ctrl.iord       = 1'b1;
        ctrl.mem_write  = 1'b1;
        // The store retires in the cycle memory accepts it.
        ctrl.instr_done = ready;
        if (ready) state_d = S_FETCH;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = 2'b10;
        state_d        = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = 2'b01;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = 2'b01;
        ctrl.branch_ne     = (op_q == OP_BNE);
        ctrl.instr_done    = 1'b1;
        state_d            = S_FETCH;
      end
      S_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = 2'b10;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_IMMEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'b10;
        state_d        = S_IMMWB;
      end
      S_IMMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      // Codes 12-15: all outputs stay 0 and the next edge recovers to FETCH.
      default: state_d = S_FETCH;
    endcase

    // Reset blanks every output immediately, including FETCH's MemRead/PCWrite.
    if (reset) ctrl = '0;
  end

  assign bus.IorD        = ctrl.iord;
  assign bus.MemRead     = ctrl.mem_read;
  assign bus.MemWrite    = ctrl.mem_write;
  assign bus.IRWrite     = ctrl.ir_write;
  assign bus.RegDst      = ctrl.reg_dst;
  assign bus.MemtoReg    = ctrl.mem_to_reg;
  assign bus.RegWrite    = ctrl.reg_write;
  assign bus.ALUSrcA     = ctrl.alu_src_a;
  assign bus.PCWrite     = ctrl.pc_write;
  assign bus.PCWriteCond = ctrl.pc_write_cond;
  assign bus.BranchNe    = ctrl.branch_ne;
  assign bus.illegal     = ctrl.illegal;
  assign bus.instr_done  = ctrl.instr_done;
  assign bus.ALUSrcB     = ctrl.alu_src_b;
  assign bus.ALUOp       = ctrl.alu_op;
  assign bus.PCSrc       = ctrl.pc_src;
  assign bus.state       = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed testbench for multicycle_control_fsm.
// dut_a: default parameters (handshake on, addi enabled).
// dut_b: MEM_HANDSHAKE=0, ENABLE_IMM=0, run with mem_ready held low.
module tb_multicycle_control_fsm;

  logic clk;
  logic reset;
  int   tests;
  int   fails;

  multicycle_control_fsm_if bus_a ();
  multicycle_control_fsm_if bus_b ();

  multicycle_control_fsm #(
    .MEM_HANDSHAKE (1),
    .ENABLE_IMM    (1)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  multicycle_control_fsm #(
    .MEM_HANDSHAKE (0),
    .ENABLE_IMM    (0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  initial begin
    tests           = 0;
    fails           = 0;
    reset           = 1'b1;
    bus_a.opcode    = 6'b000000;
    bus_a.mem_ready = 1'b1;
    bus_b.opcode    = 6'b000000;
    bus_b.mem_ready = 1'b0;

    // ---------------- reset ----------------
    tick();
    tick();
    check("rst_state",   {28'd0, bus_a.state}, 32'd0);
    check("rst_memread", {31'd0, bus_a.MemRead}, 32'd0);
    check("rst_pcwrite", {31'd0, bus_a.PCWrite}, 32'd0);

    // ---------------- lw, no stall; opcode changed after DECODE ----------------
    reset        = 1'b0;
    bus_a.opcode = 6'b100011;
    settle();
    check("lw_fetch_state",   {28'd0, bus_a.state},   32'd0);
    check("lw_fetch_memread", {31'd0, bus_a.MemRead}, 32'd1);
    check("lw_fetch_irwrite", {31'd0, bus_a.IRWrite}, 32'd1);
    check("lw_fetch_alusrcb", {30'd0, bus_a.ALUSrcB}, 32'd1);
    tick();
    check("lw_decode_state",  {28'd0, bus_a.state},   32'd1);
    check("lw_decode_alusrcb",{30'd0, bus_a.ALUSrcB}, 32'd3);
    check("lw_decode_rw",     {31'd0, bus_a.RegWrite},32'd0);
    tick();
    check("lw_memadr_state",  {28'd0, bus_a.state},   32'd2);
    check("lw_memadr_alusrcb",{30'd0, bus_a.ALUSrcB}, 32'd2);
    bus_a.opcode = 6'b101011; // must be ignored, op_q holds lw
    tick();
    check("lw_memrd_state",   {28'd0, bus_a.state},   32'd3);
    check("lw_memrd_iord",    {31'd0, bus_a.IorD},    32'd1);
    check("lw_memrd_rw",      {31'd0, bus_a.RegWrite},32'd0);
    tick();
    check("lw_memwb_state",   {28'd0, bus_a.state},   32'd4);
    check("lw_memwb_rw",      {31'd0, bus_a.RegWrite},32'd1);
    check("lw_memwb_m2r",     {31'd0, bus_a.MemtoReg},32'd1);
    check("lw_memwb_done",    {31'd0, bus_a.instr_done},32'd1);
    tick();
    check("lw_back_fetch",    {28'd0, bus_a.state},   32'd0);
    check("lw_fetch_done",    {31'd0, bus_a.instr_done},32'd0);

    // ---------------- FETCH stall ----------------
    bus_a.opcode    = 6'b101011;
    bus_a.mem_ready = 1'b0;
    settle();
    check("fstall_memread", {31'd0, bus_a.MemRead}, 32'd1);
    check("fstall_irwrite", {31'd0, bus_a.IRWrite}, 32'd0);
    check("fstall_pcwrite", {31'd0, bus_a.PCWrite}, 32'd0);
    tick();
    check("fstall_hold",    {28'd0, bus_a.state},   32'd0);
    bus_a.mem_ready = 1'b1;
    settle();
    check("fstall_release_ir", {31'd0, bus_a.IRWrite}, 32'd1);

    // ---------------- sw with 3 stall cycles in MEMWR ----------------
    tick();
    check("sw_decode", {28'd0, bus_a.state}, 32'd1);
    tick();
    check("sw_memadr", {28'd0, bus_a.state}, 32'd2);
    tick();
    bus_a.mem_ready = 1'b0;
    settle();
    check("sw_wr1_state", {28'd0, bus_a.state},      32'd5);
    check("sw_wr1_mw",    {31'd0, bus_a.MemWrite},   32'd1);
    check("sw_wr1_done",  {31'd0, bus_a.instr_done}, 32'd0);
    tick();
    check("sw_wr2_mw",    {31'd0, bus_a.MemWrite},   32'd1);
    check("sw_wr2_done",  {31'd0, bus_a.instr_done}, 32'd0);
    tick();
    check("sw_wr3_state", {28'd0, bus_a.state},      32'd5);
    check("sw_wr3_done",  {31'd0, bus_a.instr_done}, 32'd0);
    tick();
    bus_a.mem_ready = 1'b1;
    settle();
    check("sw_wr4_mw",    {31'd0, bus_a.MemWrite},   32'd1);
    check("sw_wr4_done",  {31'd0, bus_a.instr_done}, 32'd1);
    check("sw_wr4_iord",  {31'd0, bus_a.IorD},       32'd1);
    tick();
    check("sw_back_fetch",{28'd0, bus_a.state},      32'd0);

    // ---------------- R-type ----------------
    bus_a.opcode = 6'b000000;
    tick();
    tick();
    check("r_exec_state", {28'd0, bus_a.state}, 32'd6);
    check("r_exec_aluop", {30'd0, bus_a.ALUOp}, 32'd2);
    check("r_exec_srca",  {31'd0, bus_a.ALUSrcA}, 32'd1);
    tick();
    check("r_aluwb_state",{28'd0, bus_a.state},    32'd7);
    check("r_aluwb_dst",  {31'd0, bus_a.RegDst},   32'd1);
    check("r_aluwb_rw",   {31'd0, bus_a.RegWrite}, 32'd1);
    tick();
    check("r_back_fetch", {28'd0, bus_a.state}, 32'd0);

    // ---------------- bne ----------------
    bus_a.opcode = 6'b000101;
    tick();
    tick();
    check("bne_state", {28'd0, bus_a.state},       32'd8);
    check("bne_pwc",   {31'd0, bus_a.PCWriteCond}, 32'd1);
    check("bne_pcsrc", {30'd0, bus_a.PCSrc},       32'd1);
    check("bne_ne",    {31'd0, bus_a.BranchNe},    32'd1);
    check("bne_aluop", {30'd0, bus_a.ALUOp},       32'd1);
    check("bne_done",  {31'd0, bus_a.instr_done},  32'd1);
    tick();
    check("bne_back",  {28'd0, bus_a.state},       32'd0);

    // ---------------- beq ----------------
    bus_a.opcode = 6'b000100;
    tick();
    tick();
    check("beq_state", {28'd0, bus_a.state},    32'd8);
    check("beq_ne",    {31'd0, bus_a.BranchNe}, 32'd0);
    tick();

    // ---------------- j ----------------
    bus_a.opcode = 6'b000010;
    tick();
    tick();
    check("j_state",   {28'd0, bus_a.state},   32'd9);
    check("j_pcwrite", {31'd0, bus_a.PCWrite}, 32'd1);
    check("j_pcsrc",   {30'd0, bus_a.PCSrc},   32'd2);
    tick();
    check("j_back",    {28'd0, bus_a.state},   32'd0);

    // ---------------- addi (enabled) ----------------
    bus_a.opcode = 6'b001000;
    tick();
    check("addi_decode_illegal", {31'd0, bus_a.illegal}, 32'd0);
    tick();
    check("addi_immex_state",   {28'd0, bus_a.state},   32'd10);
    check("addi_immex_alusrcb", {30'd0, bus_a.ALUSrcB}, 32'd2);
    tick();
    check("addi_immwb_state",   {28'd0, bus_a.state},   32'd11);
    check("addi_immwb_rw",      {31'd0, bus_a.RegWrite},32'd1);
    check("addi_immwb_dst",     {31'd0, bus_a.RegDst},  32'd0);
    check("addi_immwb_m2r",     {31'd0, bus_a.MemtoReg},32'd0);
    tick();

    // ---------------- illegal opcode 111111 ----------------
    bus_a.opcode = 6'b111111;
    tick();
    check("ill_decode_state", {28'd0, bus_a.state},    32'd1);
    check("ill_flag",         {31'd0, bus_a.illegal},  32'd1);
    check("ill_rw",           {31'd0, bus_a.RegWrite}, 32'd0);
    tick();
    check("ill_back_fetch",   {28'd0, bus_a.state},    32'd0);
    check("ill_flag_clear",   {31'd0, bus_a.illegal},  32'd0);

    // ---------------- reset mid-MEMRD stall ----------------
    bus_a.opcode = 6'b100011;
    tick();
    tick();
    tick();
    bus_a.mem_ready = 1'b0;
    settle();
    check("rmid_memrd", {28'd0, bus_a.state}, 32'd3);
    reset = 1'b1;
    settle();
    check("rmid_memread_zero", {31'd0, bus_a.MemRead}, 32'd0);
    check("rmid_iord_zero",    {31'd0, bus_a.IorD},    32'd0);
    tick();
    check("rmid_state0",       {28'd0, bus_a.state},   32'd0);
    check("rmid_fetch_zero",   {31'd0, bus_a.MemRead}, 32'd0);
    check("rmid_pcw_zero",     {31'd0, bus_a.PCWrite}, 32'd0);
    reset           = 1'b0;
    bus_a.mem_ready = 1'b1;
    bus_b.opcode    = 6'b100011; // dut_b restarts from FETCH as well
    settle();
    check("rmid_fetch_normal", {31'd0, bus_a.MemRead}, 32'd1);
    check("rmid_fetch_pcw",    {31'd0, bus_a.PCWrite}, 32'd1);
    check("b_fetch_pcw",       {31'd0, bus_b.PCWrite}, 32'd1);
    check("b_fetch_state",     {28'd0, bus_b.state},   32'd0);

    // ---------------- dut_b: lw with mem_ready=0, no handshake ----------------
    tick();
    check("rmid_decode",  {28'd0, bus_a.state}, 32'd1);
    check("b_lw_s1",      {28'd0, bus_b.state}, 32'd1);
    tick();
    check("b_lw_s2",      {28'd0, bus_b.state}, 32'd2);
    tick();
    check("b_lw_s3",      {28'd0, bus_b.state}, 32'd3);
    tick();
    check("b_lw_s4",      {28'd0, bus_b.state}, 32'd4);
    check("b_lw_rw",      {31'd0, bus_b.RegWrite}, 32'd1);
    tick();
    check("b_lw_s0",      {28'd0, bus_b.state}, 32'd0);

    // ---------------- dut_b: sw completes in 4 cycles ----------------
    bus_b.opcode = 6'b101011;
    tick();
    tick();
    tick();
    check("b_sw_memwr", {28'd0, bus_b.state},      32'd5);
    check("b_sw_done",  {31'd0, bus_b.instr_done}, 32'd1);
    tick();
    check("b_sw_s0",    {28'd0, bus_b.state},      32'd0);

    // ---------------- dut_b: addi is illegal ----------------
    bus_b.opcode = 6'b001000;
    tick();
    check("b_addi_decode",  {28'd0, bus_b.state},    32'd1);
    check("b_addi_illegal", {31'd0, bus_b.illegal},  32'd1);
    check("b_addi_rw",      {31'd0, bus_b.RegWrite}, 32'd0);
    tick();
    check("b_addi_fetch",   {28'd0, bus_b.state},    32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
MULTICYCLE_CONTROL_FSM -- requirements
Module: multicycle_control_fsm

Interface
REQ-001 SHALL have parameter MEM_HANDSHAKE, default 1; 1 = memory states wait on mem_ready, 0 = mem_ready ignored (treated as 1).
REQ-002 SHALL have parameter ENABLE_IMM, default 1; 1 = addi (6'b001000) supported, 0 = addi treated as illegal.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high.
REQ-005 SHALL have port opcode, input, 6, instruction bits [31:26] from the datapath instruction register.
REQ-006 SHALL have port mem_ready, input, 1, memory has completed the current access this cycle.
REQ-007 SHALL have 1-bit outputs IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, PCWrite, PCWriteCond, BranchNe, illegal and instr_done.
REQ-008 SHALL have 2-bit outputs ALUSrcB, ALUOp and PCSrc, and a 4-bit output state (current state code).

Function
REQ-009 SHALL implement a Moore FSM with these codes: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IMMEX=10, IMMWB=11.
REQ-010 Every output not listed for a state SHALL be 0 in that state.
REQ-011 FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00; IRWrite=PCWrite=mem_ready.
REQ-012 FETCH transitions: to DECODE when mem_ready=1, else hold.
REQ-013 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00; latch opcode into internal op_q.
REQ-014 DECODE next state by opcode: 000000->EXEC; 100011 or 101011->MEMADR; 000100 or 000101->BRANCH; 000010->JUMP; 001000->IMMEX if ENABLE_IMM=1.
REQ-015 Any other opcode in DECODE SHALL assert illegal=1 for that cycle and return to FETCH with no register or memory write.
REQ-016 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00; to MEMRD if op_q=100011, else MEMWR.
REQ-017 MEMRD: IorD=1, MemRead=1; hold until mem_ready=1, then MEMWB.
REQ-018 MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1; then FETCH.
REQ-019 MEMWR: IorD=1, MemWrite=1; hold until mem_ready=1, then FETCH with instr_done=1 in the completing cycle.
REQ-020 EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10; then ALUWB.
REQ-021 ALUWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1; then FETCH.
REQ-022 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=01, BranchNe=(op_q==000101), instr_done=1; then FETCH.
REQ-023 JUMP: PCWrite=1, PCSrc=10, instr_done=1; then FETCH.
REQ-024 IMMEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00; then IMMWB.
REQ-025 IMMWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1; then FETCH.
REQ-026 With mem_ready always 1, cycle counts FETCH to last state inclusive SHALL be: R=4, lw=5, sw=4, beq/bne=3, j=3, addi=4.
REQ-027 Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR SHALL add exactly one cycle, with outputs held and no IRWrite/PCWrite/instr_done pulse.
REQ-028 Unencoded state values 12-15 SHALL transition to FETCH on the next edge with all outputs 0.
REQ-029 Opcode changes outside DECODE SHALL have no effect; later states use op_q only.

Reset
REQ-030 reset=1 at a clock edge SHALL force state=FETCH and op_q=0, including mid-instruction and mid-stall.
REQ-031 While reset=1, all outputs SHALL be 0, including FETCH MemRead and PCWrite.
REQ-032 The first cycle after reset deasserts SHALL be a normal FETCH.

Verification
REQ-033 lw (100011), mem_ready=1 -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; instr_done once.
REQ-034 sw with mem_ready low for 3 cycles in MEMWR -> MemWrite=1 for 4 cycles; instr_done only in the 4th.
REQ-035 bne (000101) -> BRANCH with PCWriteCond=1, PCSrc=01, BranchNe=1; beq -> BranchNe=0.
REQ-036 ENABLE_IMM=0 and addi, or opcode 111111 -> illegal=1 in DECODE, next state FETCH, RegWrite never 1.
REQ-037 reset pulsed in MEMRD -> state=0 next cycle, all outputs 0 while reset=1, normal fetch afterwards.
REQ-038 MEM_HANDSHAKE=0 with mem_ready=0 -> cycle counts identical to REQ-026.
